lzd_norm_pipe: RTL

- Pipelined mantissa normaliser that directly consumes leading-zero-detect results.
- Stage 1 registers the operand and computes the leading-zero count with an LZD tree. Stage 2 left-shifts the mantissa by that count and adjusts the exponent, with underflow clamping.
- Sits downstream of the adder/subtractor datapath, ahead of rounding. Valid/ready handshake on both sides; full throughput of one operand per cycle.

---
 rtl/arith_pkg.sv | 15 +
 rtl/lzd_nbits.sv | 63 ++++++
 rtl/lzd_norm_pipe.sv | 120 ++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic helpers for the normaliser datapath.
//   lz_width(w) : bits needed to hold a leading-zero count of 0..w
//   norm_flags_t: result flags carried alongside a normalised mantissa
package arith_pkg;

  function automatic int lz_width(input int w);
    return $clog2(w) + 1;
  endfunction

  typedef struct packed {
    logic zero;    // input mantissa was all zeros
    logic denorm;  // shift clamped by exponent, result is subnormal
  } norm_flags_t;

endpackage

// File: rtl/lzd_nbits.sv
// Leading-zero detector for a W-bit vector, built as a recursive tree.
//   din   : vector to scan, MSB first
//   count : number of consecutive zeros from din[W-1] downward (W when all zero)
//   zero  : din is all zeros
// Non power-of-two widths are padded at the LSB end with zeros up to the
// next power of two; padding only matters when din is all zero, and that
// case is forced back to W.
module lzd_nbits
  import arith_pkg::*;
#(
  parameter int W = 24
) (
  input  logic [W-1:0]           din,
  output logic [lz_width(W)-1:0] count,
  output logic                   zero
);

  localparam int CW = lz_width(W);

  if (W == 2) begin : g_leaf
    assign zero  = ~(din[1] | din[0]);
    assign count = din[1] ? 2'd0 : (din[0] ? 2'd1 : 2'd2);
  end else if ((1 << $clog2(W)) != W) begin : g_pad
    localparam int P = 1 << $clog2(W);
    logic [P-1:0]  padded;
    logic [CW-1:0] pad_count;
    logic          pad_zero;

    assign padded = {din, {(P - W){1'b0}}};

    lzd_nbits #(.W(P)) u_pad (
      .din   (padded),
      .count (pad_count),
      .zero  (pad_zero)
    );

    assign zero  = pad_zero;
    assign count = pad_zero ? CW'(W) : pad_count;
  end else begin : g_split
    localparam int H  = W / 2;
    localparam int HW = lz_width(H);
    logic [HW-1:0] hi_count, lo_count;
    logic          hi_zero, lo_zero;

    lzd_nbits #(.W(H)) u_hi (
      .din   (din[W-1:H]),
      .count (hi_count),
      .zero  (hi_zero)
    );

    lzd_nbits #(.W(H)) u_lo (
      .din   (din[H-1:0]),
      .count (lo_count),
      .zero  (lo_zero)
    );

    // When the upper half is empty the count continues into the lower half;
    // both empty gives H + H = W automatically.
    assign zero  = hi_zero & lo_zero;
    assign count = hi_zero ? (CW'(lo_count) + CW'(H)) : CW'(hi_count);
  end

endmodule

// File: rtl/lzd_norm_pipe.sv
// Two-stage mantissa normaliser.
//   Stage 1 captures the operand and its leading-zero count.
//   Stage 2 shifts the mantissa left by that count and lowers the exponent,
//   clamping at exponent 0 (subnormal result).
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   in_valid/in_ready        : upstream handshake
//   in_mant, in_exp          : unnormalised mantissa and biased exponent
//   out_valid/out_ready      : downstream handshake
//   out_mant, out_exp        : normalised mantissa and adjusted exponent
//   out_lz                   : true leading-zero count of the input mantissa
//   out_zero, out_denorm     : all-zero input / clamped (subnormal) result
module lzd_norm_pipe
  import arith_pkg::*;
#(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8,
  parameter int LZ_W   = lz_width(MANT_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic [LZ_W-1:0]   out_lz,
  output logic              out_zero,
  output logic              out_denorm
);

  localparam int CMP_W = (EXP_W > LZ_W) ? EXP_W : LZ_W;

  logic              s1_valid;
  logic [MANT_W-1:0] s1_mant;
  logic [EXP_W-1:0]  s1_exp;
  logic [LZ_W-1:0]   s1_lz;
  logic              s1_zero;

  logic              s2_adv, s1_adv;
  logic [LZ_W-1:0]   lzd_count;
  logic              lzd_zero;

  logic [MANT_W-1:0] n_mant;
  logic [EXP_W-1:0]  n_exp;
  norm_flags_t       n_flags, out_flags;
  logic [CMP_W-1:0]  exp_c, lz_c, exp_diff;

  // Ready chain runs combinationally from out_ready back to in_ready.
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  lzd_nbits #(.W(MANT_W)) u_lzd (
    .din   (in_mant),
    .count (lzd_count),
    .zero  (lzd_zero)
  );

  assign exp_c    = CMP_W'(s1_exp);
  assign lz_c     = CMP_W'(s1_lz);
  assign exp_diff = exp_c - lz_c;

  always_comb begin
    n_mant  = '0;
    n_exp   = '0;
    n_flags = '0;
    if (s1_zero) begin
      n_flags.zero = 1'b1;
    end else if (exp_c > lz_c) begin
      n_mant = s1_mant << s1_lz;
      n_exp  = exp_diff[EXP_W-1:0];
    end else begin
      // exp <= lz < MANT_W here, so the clamped shift never empties the word.
      n_mant         = s1_mant << s1_exp;
      n_flags.denorm = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_mant   <= '0;
      s1_exp    <= '0;
      s1_lz     <= '0;
      s1_zero   <= 1'b0;
      out_valid <= 1'b0;
      out_mant  <= '0;
      out_exp   <= '0;
      out_lz    <= '0;
      out_flags <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_mant <= in_mant;
          s1_exp  <= in_exp;
          s1_lz   <= lzd_count;
          s1_zero <= lzd_zero;
        end
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_mant  <= n_mant;
          out_exp   <= n_exp;
          out_lz    <= s1_lz;
          out_flags <= n_flags;
        end
      end
    end
  end

  assign out_zero   = out_flags.zero;
  assign out_denorm = out_flags.denorm;

endmodule
